// File: rtl/console_pkg.sv
// Shared definitions for the text console controller: geometry defaults,
// control character codes, FSM states and cursor operations.
package console_pkg;

   localparam int unsigned COLS_DEF  = 30;
   localparam int unsigned ROWS_DEF  = 25;
   localparam logic [7:0]  BLANK_DEF = 8'h20;

   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   typedef enum logic {
      StIdle,
      StClear
   } state_t;

   typedef enum logic [2:0] {
      CurHold,
      CurAdvance,
      CurNewline,
      CurReturn,
      CurBack,
      CurZero
   } cur_op_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position kept as separate column/row counters; the linear cell
// address is rebuilt with a constant multiply so no divider is ever needed.
module console_cursor
   import console_pkg::*;
#(
   parameter int unsigned COLS = COLS_DEF,
   parameter int unsigned ROWS = ROWS_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [2:0]  i_op,
   output logic [11:0] o_cursor,
   output logic        o_col_zero
);

   localparam logic [11:0] LAST_COL = 12'(COLS - 1);
   localparam logic [11:0] LAST_ROW = 12'(ROWS - 1);

   logic [11:0] r_col;
   logic [11:0] r_row;
   logic [11:0] r_cursor;
   logic [11:0] w_col_d;
   logic [11:0] w_row_d;
   logic [11:0] w_cursor_d;

   // Next column/row for the requested operation, plus the matching address.
   always_comb begin
      w_col_d = r_col;
      w_row_d = r_row;
      case (cur_op_t'(i_op))
         CurAdvance: begin
            if (r_col == LAST_COL) begin
               w_col_d = '0;
               w_row_d = (r_row == LAST_ROW) ? '0 : r_row + 12'd1;
            end else begin
               w_col_d = r_col + 12'd1;
            end
         end
         CurNewline: w_row_d = (r_row == LAST_ROW) ? '0 : r_row + 12'd1;
         CurReturn:  w_col_d = '0;
         CurBack:    if (r_col != '0) w_col_d = r_col - 12'd1;
         CurZero: begin
            w_col_d = '0;
            w_row_d = '0;
         end
         default: ;
      endcase
      w_cursor_d = 12'((w_row_d * COLS) + w_col_d);
   end

   // Counters and the registered linear address move together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_col    <= '0;
         r_row    <= '0;
         r_cursor <= '0;
      end else begin
         r_col    <= w_col_d;
         r_row    <= w_row_d;
         r_cursor <= w_cursor_d;
      end
   end

   assign o_cursor   = r_cursor;
   assign o_col_zero = (r_col == '0);

endmodule

// File: rtl/console_ctrl.sv
// Text console controller: turns a UART character stream and direct host
// cell writes into single-cycle VRAM write strobes, and sweeps the whole
// screen with blanks on a clear request.
module console_ctrl
   import console_pkg::*;
#(
   parameter int unsigned COLS  = COLS_DEF,
   parameter int unsigned ROWS  = ROWS_DEF,
   parameter logic [7:0]  BLANK = BLANK_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_char_valid,
   input  logic [7:0]  i_char_data,
   output logic        o_char_ready,
   input  logic        i_host_req,
   input  logic [11:0] i_host_addr,
   input  logic [7:0]  i_host_data,
   output logic        o_host_ack,
   input  logic        i_clear_req,
   output logic        o_vram_ce,
   output logic [11:0] o_vram_addr,
   output logic [7:0]  o_vram_data,
   output logic [11:0] o_cursor,
   output logic        o_busy
);

   localparam logic [11:0] CELLS     = 12'(COLS * ROWS);
   localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

   state_t      r_state;
   state_t      w_state_d;
   logic        r_clear_pend;
   logic        w_pend_d;
   logic        r_vram_ce;
   logic        w_ce_d;
   logic [11:0] r_vram_addr;
   logic [11:0] w_addr_d;
   logic [7:0]  r_vram_data;
   logic [7:0]  w_data_d;
   logic        r_host_ack;
   logic        w_ack_d;
   cur_op_t     w_op;
   logic        w_start_clear;
   logic        w_host_take;
   logic        w_char_take;
   logic        w_col_zero;
   logic [11:0] w_cursor;

   console_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_op       (w_op),
      .o_cursor   (w_cursor),
      .o_col_zero (w_col_zero)
   );

   // A host request already acked this cycle is not taken a second time.
   assign w_host_take  = (r_state == StIdle) & i_host_req & ~r_host_ack;
   assign o_char_ready = (r_state == StIdle) & ~i_host_req & ~i_clear_req & ~r_clear_pend
                         & ~i_reset;
   assign w_char_take  = i_char_valid & o_char_ready;

   // Next state, next strobe contents and cursor operation.
   always_comb begin
      w_state_d     = r_state;
      w_pend_d      = r_clear_pend;
      w_ce_d        = 1'b0;
      w_addr_d      = r_vram_addr;
      w_data_d      = r_vram_data;
      w_ack_d       = 1'b0;
      w_op          = CurHold;
      w_start_clear = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_host_take) begin
               w_ack_d = 1'b1;
               if (i_host_addr < CELLS) begin
                  w_ce_d   = 1'b1;
                  w_addr_d = i_host_addr;
                  w_data_d = i_host_data;
               end
               if (i_clear_req) w_pend_d = 1'b1;
            end else if (i_clear_req || r_clear_pend) begin
               w_start_clear = 1'b1;
            end else if (w_char_take) begin
               if (is_printable(i_char_data)) begin
                  w_ce_d   = 1'b1;
                  w_addr_d = w_cursor;
                  w_data_d = i_char_data;
                  w_op     = CurAdvance;
               end else begin
                  case (i_char_data)
                     CH_CR: w_op = CurReturn;
                     CH_LF: w_op = CurNewline;
                     CH_BS: begin
                        if (!w_col_zero) begin
                           w_ce_d   = 1'b1;
                           w_addr_d = w_cursor - 12'd1;
                           w_data_d = BLANK;
                           w_op     = CurBack;
                        end
                     end
                     CH_FF:   w_start_clear = 1'b1;
                     default: ;
                  endcase
               end
            end
         end
         StClear: begin
            // r_vram_addr doubles as the sweep counter: it holds the cell
            // being strobed this cycle.
            if (r_vram_addr == LAST_ADDR) begin
               w_state_d = StIdle;
               w_op      = CurZero;
            end else begin
               w_ce_d   = 1'b1;
               w_addr_d = r_vram_addr + 12'd1;
               w_data_d = BLANK;
            end
         end
      endcase
      if (w_start_clear) begin
         w_state_d = StClear;
         w_pend_d  = 1'b0;
         w_ce_d    = 1'b1;
         w_addr_d  = '0;
         w_data_d  = BLANK;
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_clear_pend <= 1'b0;
         r_vram_ce    <= 1'b0;
         r_vram_addr  <= '0;
         r_vram_data  <= '0;
         r_host_ack   <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_clear_pend <= w_pend_d;
         r_vram_ce    <= w_ce_d;
         r_vram_addr  <= w_addr_d;
         r_vram_data  <= w_data_d;
         r_host_ack   <= w_ack_d;
      end
   end

   // Strobes are masked by reset so an aborted clear stops within the cycle.
   assign o_vram_ce   = r_vram_ce & ~i_reset;
   assign o_host_ack  = r_host_ack & ~i_reset;
   assign o_busy      = (r_state == StClear) & ~i_reset;
   assign o_vram_addr = r_vram_addr;
   assign o_vram_data = r_vram_data;
   assign o_cursor    = w_cursor;

endmodule

// File: tb/tb_console_ctrl.sv
// Bench for console_ctrl: table of character vectors plus hand-written
// host/clear/reset sequences; every VRAM strobe is checked against a queue.
module tb_console_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        host_req;
   logic [11:0] host_addr;
   logic [7:0]  host_data;
   logic        host_ack;
   logic        clear_req;
   logic        vram_ce;
   logic [11:0] vram_addr;
   logic [7:0]  vram_data;
   logic [11:0] cursor;
   logic        busy;

   always #5 clk = ~clk;

   console_ctrl dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_char_valid (char_valid),
      .i_char_data  (char_data),
      .o_char_ready (char_ready),
      .i_host_req   (host_req),
      .i_host_addr  (host_addr),
      .i_host_data  (host_data),
      .o_host_ack   (host_ack),
      .i_clear_req  (clear_req),
      .o_vram_ce    (vram_ce),
      .o_vram_addr  (vram_addr),
      .o_vram_data  (vram_data),
      .o_cursor     (cursor),
      .o_busy       (busy)
   );

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
   } exp_t;

   typedef struct {
      logic [7:0]  ch;
      bit          wr;
      logic [11:0] addr;
      logic [7:0]  data;
      logic [11:0] cur;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and score any strobe seen there.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (vram_ce) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got (%0d,%h) required none", vram_addr, vram_data);
         end else begin
            e = sb.pop_front();
            if (vram_addr !== e.addr || vram_data !== e.data) begin
               n_fail++;
               $display("FAIL strobe: got (%0d,%h) required (%0d,%h)",
                        vram_addr, vram_data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic expect_wr(input logic [11:0] a, input logic [7:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic expect_sweep();
      for (int i = 0; i < 750; i++) expect_wr(12'(i), 8'h20);
   endtask

   task automatic send_char(input logic [7:0] ch, input bit wr, input logic [11:0] a,
                            input logic [7:0] d);
      bit ok = 1'b0;
      char_valid = 1'b1;
      char_data  = ch;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (char_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("char_accept", 32'(ok), 32'd1);
      if (wr) expect_wr(a, d);
      tick();
      char_valid = 1'b0;
   endtask

   // Count busy cycles (first busy sample already taken by the caller's tick).
   task automatic wait_clear(input int poke, output int cyc);
      cyc = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!busy) break;
         clear_req = (cyc == poke);
         if (cyc == poke + 1) begin
            #1;
            check("ready_in_clear", 32'(char_ready), 32'd0);
         end
         cyc++;
         tick();
      end
      clear_req = 1'b0;
   endtask

   initial begin
      int cyc;
      reset      = 1'b1;
      char_valid = 1'b0;
      char_data  = '0;
      host_req   = 1'b0;
      host_addr  = '0;
      host_data  = '0;
      clear_req  = 1'b0;

      vecs.push_back('{8'h41, 1'b1, 12'd0,  8'h41, 12'd1});
      vecs.push_back('{8'h42, 1'b1, 12'd1,  8'h42, 12'd2});
      vecs.push_back('{8'h01, 1'b0, 12'd0,  8'h00, 12'd2});
      vecs.push_back('{8'h08, 1'b1, 12'd1,  8'h20, 12'd1});
      vecs.push_back('{8'h0D, 1'b0, 12'd0,  8'h00, 12'd0});
      vecs.push_back('{8'h08, 1'b0, 12'd0,  8'h00, 12'd0});
      vecs.push_back('{8'h0A, 1'b0, 12'd0,  8'h00, 12'd30});
      vecs.push_back('{8'h78, 1'b1, 12'd30, 8'h78, 12'd31});
      vecs.push_back('{8'h7F, 1'b0, 12'd0,  8'h00, 12'd31});
      vecs.push_back('{8'h7E, 1'b1, 12'd31, 8'h7E, 12'd32});
      vecs.push_back('{8'h1F, 1'b0, 12'd0,  8'h00, 12'd32});
      vecs.push_back('{8'h61, 1'b1, 12'd32, 8'h61, 12'd33});
      vecs.push_back('{8'h62, 1'b1, 12'd33, 8'h62, 12'd34});
      vecs.push_back('{8'h63, 1'b1, 12'd34, 8'h63, 12'd35});
      vecs.push_back('{8'h0D, 1'b0, 12'd0,  8'h00, 12'd30});
      vecs.push_back('{8'h0A, 1'b0, 12'd0,  8'h00, 12'd60});
      vecs.push_back('{8'h08, 1'b0, 12'd0,  8'h00, 12'd60});

      // Reset state
      repeat (3) tick();
      check("rst_ready", 32'(char_ready), 32'd0);
      check("rst_ack", 32'(host_ack), 32'd0);
      check("rst_ce", 32'(vram_ce), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cursor", 32'(cursor), 32'd0);
      check("rst_addr", 32'(vram_addr), 32'd0);
      check("rst_data", 32'(vram_data), 32'd0);
      reset = 1'b0;

      // Character table
      foreach (vecs[i]) begin
         send_char(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].cur));
      end

      // Row wrap on LF, then walk to the last cell and wrap with a print
      for (int i = 0; i < 22; i++) send_char(8'h0A, 1'b0, 12'd0, 8'h00);
      check("lf_row24", 32'(cursor), 32'd720);
      send_char(8'h0A, 1'b0, 12'd0, 8'h00);
      check("lf_wrap", 32'(cursor), 32'd0);
      for (int i = 0; i < 24; i++) send_char(8'h0A, 1'b0, 12'd0, 8'h00);
      for (int i = 0; i < 29; i++) send_char(8'h78, 1'b1, 12'(720 + i), 8'h78);
      check("cursor_749", 32'(cursor), 32'd749);
      send_char(8'h5A, 1'b1, 12'd749, 8'h5A);
      check("print_wrap", 32'(cursor), 32'd0);

      // Host write has priority over a simultaneous character
      host_req   = 1'b1;
      host_addr  = 12'd100;
      host_data  = 8'h55;
      char_valid = 1'b1;
      char_data  = 8'h51;
      #1;
      check("prio_ready_lo", 32'(char_ready), 32'd0);
      expect_wr(12'd100, 8'h55);
      tick();
      check("prio_ack", 32'(host_ack), 32'd1);
      check("prio_cursor_hold", 32'(cursor), 32'd0);
      #1;
      check("ack_cycle_ready_lo", 32'(char_ready), 32'd0);
      host_req = 1'b0;
      #1;
      check("prio_ready_hi", 32'(char_ready), 32'd1);
      expect_wr(12'd0, 8'h51);
      tick();
      char_valid = 1'b0;
      check("ack_one_cycle", 32'(host_ack), 32'd0);
      check("prio_char_cursor", 32'(cursor), 32'd1);

      // Out-of-range host write: ack, no strobe
      host_req  = 1'b1;
      host_addr = 12'd800;
      host_data = 8'hAA;
      tick();
      check("oor_ack", 32'(host_ack), 32'd1);
      check("oor_no_ce", 32'(vram_ce), 32'd0);
      host_req = 1'b0;
      tick();
      check("oor_cursor", 32'(cursor), 32'd1);

      // Clear sweep with a clear_req poked mid-sweep
      clear_req = 1'b1;
      expect_sweep();
      tick();
      clear_req = 1'b0;
      wait_clear(10, cyc);
      check("clr_busy_cycles", 32'(cyc), 32'd750);
      check("clr_cursor", 32'(cursor), 32'd0);
      tick();
      check("clr_drained", 32'(sb.size()), 32'd0);
      check("clr_no_rerun", 32'(busy), 32'd0);

      // Host and clear together: host first, clear pending
      host_req  = 1'b1;
      host_addr = 12'd5;
      host_data = 8'h33;
      clear_req = 1'b1;
      expect_wr(12'd5, 8'h33);
      expect_sweep();
      tick();
      clear_req = 1'b0;
      check("hc_ack", 32'(host_ack), 32'd1);
      check("hc_not_busy", 32'(busy), 32'd0);
      host_req = 1'b0;
      tick();
      check("hc_busy", 32'(busy), 32'd1);
      wait_clear(-5, cyc);
      check("hc_busy_cycles", 32'(cyc), 32'd750);
      check("hc_drained", 32'(sb.size()), 32'd0);

      // Character and clear together: clear wins, character dropped
      send_char(8'h41, 1'b1, 12'd0, 8'h41);
      char_valid = 1'b1;
      char_data  = 8'h43;
      clear_req  = 1'b1;
      #1;
      check("cc_ready_lo", 32'(char_ready), 32'd0);
      expect_sweep();
      tick();
      clear_req  = 1'b0;
      char_valid = 1'b0;
      wait_clear(-5, cyc);
      check("cc_busy_cycles", 32'(cyc), 32'd750);
      check("cc_cursor", 32'(cursor), 32'd0);
      tick();
      check("cc_drained", 32'(sb.size()), 32'd0);

      // Reset aborts a clear at address 300
      send_char(8'h41, 1'b1, 12'd0, 8'h41);
      clear_req = 1'b1;
      expect_sweep();
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (vram_ce && vram_addr == 12'd300) break;
         tick();
      end
      check("abort_at300", 32'(vram_addr), 32'd300);
      reset      = 1'b1;
      char_valid = 1'b1;
      char_data  = 8'h4B;
      #1;
      check("abort_ce", 32'(vram_ce), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(char_ready), 32'd0);
      sb.delete();
      repeat (3) tick();
      check("abort_cursor", 32'(cursor), 32'd0);
      check("abort_addr", 32'(vram_addr), 32'd0);
      check("abort_data", 32'(vram_data), 32'd0);
      check("abort_busy2", 32'(busy), 32'd0);

      // First request right after reset deasserts
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(char_ready), 32'd1);
      expect_wr(12'd0, 8'h4B);
      tick();
      char_valid = 1'b0;
      check("post_rst_cursor", 32'(cursor), 32'd1);
      repeat (3) tick();
      check("final_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/console_ctrl.md
CONSOLE_CTRL -- requirements
Module: console_ctrl

Interface
REQ-001 Parameter COLS, default 30, text columns per row.
REQ-002 Parameter ROWS, default 25, text rows; cell count COLS*ROWS = 750, addresses 0..749.
REQ-003 Parameter BLANK, default 8'h20, fill character for clear and backspace.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 char_valid  in  1  character stream request, from the UART receive path.
REQ-007 char_data  in  8  character code, valid while char_valid is high.
REQ-008 char_ready  out  1  a character is accepted on a cycle where char_valid and char_ready are both high.
REQ-009 host_req  in  1  direct cell write request, from the MCU side; level, held until acked.
REQ-010 host_addr  in  12  cell address for a host write.
REQ-011 host_data  in  8  cell data for a host write.
REQ-012 host_ack  out  1  one-cycle pulse when the host write is consumed.
REQ-013 clear_req  in  1  one-cycle request to clear the screen.
REQ-014 vram_ce  out  1  one-cycle VRAM write strobe.
REQ-015 vram_addr  out  12  VRAM cell address, valid with vram_ce.
REQ-016 vram_data  out  8  VRAM cell data, valid with vram_ce.
REQ-017 cursor  out  12  current cursor cell address, always 0..749.
REQ-018 busy  out  1  high while in state CLEAR.

Function
REQ-019 States: IDLE and CLEAR only; all outputs are registered.
REQ-020 In IDLE, char_ready is high only when host_req is low; host writes have fixed priority over characters.
REQ-021 When a host write or character is taken at edge N, the VRAM strobe is driven during cycle N+1, with vram_ce high for exactly one cycle.
REQ-022 Host write with host_addr < 750: drive vram_ce/vram_addr/vram_data = host_addr/host_data, pulse host_ack in the same cycle, and leave the cursor unchanged.
REQ-023 Host write with host_addr >= 750: pulse host_ack and drive no vram_ce.
REQ-024 Printable character 8'h20..8'h7E: write it at the cursor, then advance the cursor by 1; 749 wraps to 0.
REQ-025 CR 8'h0D: move the cursor to column 0 of the same row, with no write.
REQ-026 LF 8'h0A: move the cursor to the same column on the next row; row ROWS-1 wraps to row 0; no write.
REQ-027 BS 8'h08: if column > 0, move the cursor back 1 and write BLANK there; at column 0, do nothing.
REQ-028 FF 8'h0C or clear_req in IDLE: enter CLEAR.
REQ-029 Any other character code is consumed and ignored.
REQ-030 Track the cursor as col/row counters and compute cursor = row*COLS + col; no divider.
REQ-031 In CLEAR, write BLANK to addresses 0..749 on consecutive cycles, one per cycle, 750 strobes in total.
REQ-032 In CLEAR, hold char_ready and host_ack low.
REQ-033 After the 749 write, enter IDLE with cursor = 0.
REQ-034 clear_req received during CLEAR is ignored.
REQ-035 clear_req and host_req in the same IDLE cycle: the host write is served first and clear_req is latched pending.
REQ-036 clear_req and a character in the same IDLE cycle: the clear wins and the character is not accepted.

Reset
REQ-037 While reset is high, char_ready, host_ack, vram_ce and busy are 0.
REQ-038 Reset forces vram_addr = 0, vram_data = 0, cursor = 0 and state IDLE.
REQ-039 Reset clears any pending clear request.
REQ-040 Reset asserted mid-CLEAR aborts the clear immediately; no further strobes are driven.
REQ-041 The first request can be accepted on the cycle after reset deasserts.

Structure
REQ-042 A shared package console_pkg holds COLS/ROWS/BLANK defaults, the control codes (CR, LF, BS, FF) and the state enum.
REQ-043 One sub-module, console_cursor, holds the col/row counters with advance, newline, return, back and zero operations.

Verification
REQ-044 After reset, send "AB" -> two strobes, (0,8'h41) then (1,8'h42); cursor = 2.
REQ-045 Cursor at 749, send "Z" -> strobe (749,8'h5A); cursor = 0.
REQ-046 Cursor at 35, send CR, LF, then BS -> cursor goes 30 then 60; BS at column 0 drives no strobe.
REQ-047 Pulse clear_req -> busy high for 750 cycles; 750 strobes of 8'h20 at addresses 0..749 in order; cursor = 0 afterwards.
REQ-048 Assert host_req (addr 100, data 8'h55) together with char_valid -> host write (100,8'h55) and host_ack first; the character is accepted on the next cycle.
REQ-049 Host write to addr 800 -> host_ack pulses with no strobe; reset at clear address 300 -> no strobes after reset and cursor = 0.
